fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Single-clock synchronous FIFO; next generation of the team's basic FIFO.
- All DEPTH entries are usable, and DEPTH may be any integer >= 2, including non-powers of two.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, synchronous flush, and a selectable read mode: first-word-fall-through or registered standard.
- Used as the generic buffering primitive between pipeline stages in the data path.

Parameters:
WIDTH, 8, data word width in bits (>= 1)
DEPTH, 32, number of storage entries (>= 2, any integer)
FWFT, 1, read mode: 1 = first-word-fall-through, 0 = standard registered read
AF_THRESH, DEPTH-2, ALMOST_FULL asserted when COUNT >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, ALMOST_EMPTY asserted when COUNT <= AE_THRESH (0..DEPTH-1)

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-low reset
FLUSH  in  1  synchronous active-high clear; lower priority than RESET
DIN  in  WIDTH  write data
WE  in  1  write request
RE  in  1  read request
DOUT  out  WIDTH  read data
DOUT_VALID  out  1  DOUT holds valid data (meaning depends on mode)
COUNT  out  CW  occupancy, where CW = clog2(DEPTH+1)
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
ALMOST_FULL  out  1  COUNT >= AF_THRESH
ALMOST_EMPTY  out  1  COUNT <= AE_THRESH
OVERFLOW  out  1  one-cycle pulse: a write was rejected
UNDERFLOW  out  1  one-cycle pulse: a read was rejected

Behaviour:
- Reset (RESET=0 at an edge) clears:
  - write pointer, read pointer, COUNT = 0
  - OVERFLOW = UNDERFLOW = 0
  - FWFT=0 output register: DOUT = 0, DOUT_VALID = 0
- Storage array is not reset. Resulting outputs after reset: EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
- FLUSH=1 (with RESET=1) has the same effect as reset. WE and RE are ignored that cycle and no error pulses are generated.
- Write acceptance: wr_ok = WE & !FULL. A write when FULL is rejected even if a read is accepted in the same cycle. A rejected write sets OVERFLOW=1 for the next cycle only.
- Read acceptance: rd_ok = RE & !EMPTY. A read when EMPTY is rejected even if a write occurs in the same cycle. A rejected read sets UNDERFLOW=1 for the next cycle only.
- Pointer update:
  - On wr_ok: mem[wp] <= DIN, and wp advances.
  - On rd_ok: rp advances.
  - Each pointer wraps from DEPTH-1 to 0. No power-of-two aliasing is permitted.
- COUNT update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither occur
  - Never exceeds DEPTH and never underflows.
- All flags are derived combinationally from registered COUNT, so they reflect an operation one cycle after its clock edge.
- FWFT=1 mode:
  - DOUT = mem[rp] combinationally when !EMPTY; DOUT = 0 when EMPTY.
  - DOUT_VALID = !EMPTY.
  - Write-to-DOUT latency is 1 cycle: a word written into an empty FIFO appears on DOUT the cycle after WE.
  - RE acts as an acknowledge of the current DOUT.
- FWFT=0 mode:
  - On rd_ok, DOUT <= mem[rp] at the same edge, and DOUT_VALID=1 for exactly the following cycle.
  - Read latency is 1 cycle. DOUT holds its last value otherwise.
  - Back-to-back reads produce back-to-back valid words.
- Simultaneous read and write with 0 < COUNT < DEPTH: both are accepted, COUNT is unchanged, and data order is preserved.
- Reset or flush mid-stream: all stored data is discarded. The next write after release is the next word read.

Test Plan:
1. DEPTH=5, WIDTH=8, FWFT=1. Reset, then write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles → COUNT 1..5, FULL=1 after the 5th write, ALMOST_FULL=1 from COUNT=3 (AF_THRESH=3). A 6th write of 0x66 → OVERFLOW pulses 1 cycle and COUNT stays 5.
2. Continue from scenario 1: assert RE for 5 cycles → DOUT sequence 0x11,0x22,0x33,0x44,0x55 in order through the wrap point. EMPTY=1 afterwards and DOUT=0. A 6th RE → UNDERFLOW pulses 1 cycle.
3. FWFT=1, COUNT=2: WE and RE together for 10 cycles with DIN = 0x00..0x09 → COUNT stays 2 and the read stream is the two old words followed by 0x00..0x07. Pointers wrap twice with no data loss.
4. FWFT=1, full (COUNT=5): WE=RE=1 → read accepted, write rejected, OVERFLOW=1, COUNT=4. Empty: WE=RE=1 with DIN=0xA5 → write accepted, UNDERFLOW=1, COUNT=1, DOUT=0xA5 the next cycle.
5. FWFT=0: write 0x10,0x20, then RE for 2 cycles → DOUT=0x10 then 0x20, each with DOUT_VALID=1 exactly one cycle after its RE. DOUT holds 0x20 afterwards with DOUT_VALID=0.
6. COUNT=3, then FLUSH=1 concurrently with WE=1 → COUNT=0, EMPTY=1, no OVERFLOW. Repeat with RESET=0 mid-burst → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with any DEPTH >= 2, occupancy count, thresholds,
// error pulses, synchronous flush and selectable FWFT or registered read.
module fifo_sync_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] DIN,
    input  logic             WE,
    input  logic             RE,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d, udf_q, udf_d, dv_q, dv_d;
    logic             clr, wr_ok, rd_ok;

    assign clr   = !RESET || FLUSH;
    assign FULL  = count_q == CW'(DEPTH);
    assign EMPTY = count_q == '0;
    assign wr_ok = WE && !FULL;
    assign rd_ok = RE && !EMPTY;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths use every entry.
    always_comb begin
        wp_d    = wr_ok ? (wp_q == AW'(DEPTH - 1) ? '0 : wp_q + AW'(1)) : wp_q;
        rp_d    = rd_ok ? (rp_q == AW'(DEPTH - 1) ? '0 : rp_q + AW'(1)) : rp_q;
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
        ovf_d   = WE && FULL;
        udf_d   = RE && EMPTY;
        dout_d  = (FWFT == 0 && rd_ok) ? mem[rp_q] : dout_q;
        dv_d    = FWFT == 0 && rd_ok;
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok && !clr) mem[wp_q] <= DIN;
    end

    assign COUNT        = count_q;
    assign ALMOST_FULL  = count_q >= CW'(AF_THRESH);
    assign ALMOST_EMPTY = count_q <= CW'(AE_THRESH);
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;
    assign DOUT         = FWFT != 0 ? (EMPTY ? '0 : mem[rp_q]) : dout_q;
    assign DOUT_VALID   = FWFT != 0 ? !EMPTY : dv_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of a DEPTH=5 FIFO, one FWFT and one registered-read
// instance driven by the same stimulus.
module tb_fifo_sync_param;
    logic       CLK = 1'b0, RESET = 1'b0, FLUSH = 1'b0, WE = 1'b0, RE = 1'b0;
    logic [7:0] DIN = '0;
    logic [7:0] d1_dout, d0_dout;
    logic [2:0] d1_count, d0_count;
    logic       d1_dv, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;
    logic       d0_dv, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
    int         compared = 0, mismatched = 0;
    logic [7:0] exp_q [$];

    always #5 CLK = ~CLK;

    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u1 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .DIN(DIN), .WE(WE), .RE(RE),
        .DOUT(d1_dout), .DOUT_VALID(d1_dv), .COUNT(d1_count), .FULL(d1_full), .EMPTY(d1_empty),
        .ALMOST_FULL(d1_af), .ALMOST_EMPTY(d1_ae), .OVERFLOW(d1_ovf), .UNDERFLOW(d1_udf));

    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u0 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .DIN(DIN), .WE(WE), .RE(RE),
        .DOUT(d0_dout), .DOUT_VALID(d0_dv), .COUNT(d0_count), .FULL(d0_full), .EMPTY(d0_empty),
        .ALMOST_FULL(d0_af), .ALMOST_EMPTY(d0_ae), .OVERFLOW(d0_ovf), .UNDERFLOW(d0_udf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [7:0] din);
        WE = we; RE = re; DIN = din;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"}, 32'(d1_count), 0);
        chk({tag, " flags"}, {d1_empty, d1_full, d1_ae, d1_af, d1_ovf, d1_udf}, 6'b101000);
        chk({tag, " dout1"}, {d1_dv, d1_dout}, 9'h000);
        chk({tag, " dout0"}, {d0_dv, d0_dout}, 9'h000);
        chk({tag, " count0"}, 32'(d0_count), 0);
    endtask

    initial begin
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk_reset_state("reset");
        RESET = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'h11 * 8'(i + 1));
            chk("fill count", 32'(d1_count), 32'(i + 1));
            chk("fill af", 32'(d1_af), 32'(i + 1 >= 3));
            chk("fill full", 32'(d1_full), 32'(i == 4));
            chk("fill head", 32'(d1_dout), 32'h11);
        end
        step(1, 0, 8'h66);
        chk("ovf pulse", 32'(d1_ovf), 1);
        chk("ovf count", 32'(d1_count), 5);
        step(0, 0, 8'h00);
        chk("ovf clear", 32'(d1_ovf), 0);

        // Drain through the wrap; registered instance delivers each word one cycle later.
        for (int i = 0; i < 5; i++) begin
            chk("drain fwft", 32'(d1_dout), 32'h11 * (i + 1));
            step(0, 1, 8'h00);
            chk("drain reg", {d0_dv, d0_dout}, {1'b1, 8'h11 * 8'(i + 1)});
        end
        chk("drain empty", {d1_empty, d1_dv, d1_dout}, 10'h200);
        step(0, 1, 8'h00);
        chk("udf pulse", 32'(d1_udf), 1);
        chk("udf reg hold", {d0_dv, d0_dout}, 9'h055);
        step(0, 0, 8'h00);
        chk("udf clear", 32'(d1_udf), 0);

        // Streaming read+write at COUNT=2, wrapping both pointers twice.
        step(1, 0, 8'hA0);
        step(1, 0, 8'hA1);
        exp_q = '{8'hA0, 8'hA1};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'(i));
            chk("stream dout", 32'(d1_dout), 32'(exp_q.pop_front()));
            step(1, 1, 8'(i));
            chk("stream count", 32'(d1_count), 2);
        end
        chk("stream tail", 32'(d1_dout), 32'h08);

        // Full with WE+RE: read accepted, write rejected.
        step(1, 0, 8'hB0);
        step(1, 0, 8'hB1);
        step(1, 0, 8'hB2);
        chk("full before", 32'(d1_full), 1);
        step(1, 1, 8'hC0);
        chk("full wr+rd ovf", 32'(d1_ovf), 1);
        chk("full wr+rd count", 32'(d1_count), 4);
        chk("full wr+rd dout", 32'(d1_dout), 32'h09);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
        chk("drain2 empty", 32'(d1_empty), 1);

        // Empty with WE+RE: write accepted, read rejected.
        step(1, 1, 8'hA5);
        chk("empty wr+rd udf", 32'(d1_udf), 1);
        chk("empty wr+rd count", 32'(d1_count), 1);
        chk("empty wr+rd dout", {d1_dv, d1_dout}, 9'h1A5);
        chk("empty wr+rd reg dv", 32'(d0_dv), 0);
        step(0, 1, 8'h00);

        // Registered read mode: one-cycle latency, back-to-back valid, then hold.
        step(1, 0, 8'h10);
        step(1, 0, 8'h20);
        chk("reg idle dv", 32'(d0_dv), 0);
        step(0, 1, 8'h00);
        chk("reg rd1", {d0_dv, d0_dout}, 9'h110);
        step(0, 1, 8'h00);
        chk("reg rd2", {d0_dv, d0_dout}, 9'h120);
        step(0, 0, 8'h00);
        chk("reg hold", {d0_dv, d0_dout}, 9'h020);

        // Flush with a concurrent write discards everything and ignores the write.
        step(1, 0, 8'h31);
        step(1, 0, 8'h32);
        step(1, 0, 8'h33);
        chk("pre flush count", 32'(d1_count), 3);
        FLUSH = 1'b1;
        step(1, 0, 8'h77);
        FLUSH = 1'b0;
        chk_reset_state("flush");
        step(1, 0, 8'h88);
        chk("post flush head", {d1_dv, d1_dout}, 9'h188);

        // Reset mid-burst with a registered word pending on DOUT.
        step(1, 0, 8'h90);
        step(1, 1, 8'h91);
        chk("pre reset reg", {d0_dv, d0_dout}, 9'h188);
        RESET = 1'b0;
        step(1, 1, 8'h92);
        chk_reset_state("midreset");
        RESET = 1'b1;
        step(1, 0, 8'h93);
        chk("post reset head", {d1_dv, d1_dout, 5'(d1_count)}, {9'h193, 5'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
